foc_sample_seq: RTL and testbench
=================================

FOC_SAMPLE_SEQ -- requirements
Module: foc_sample_seq

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 16, data width of current and angle words.
REQ-002 The block SHALL have parameter CAL_SHIFT, default 4; calibration averages 2^CAL_SHIFT sequences.
REQ-003 The block SHALL have port clk  input  1  clock.
REQ-004 The block SHALL have port rstb  input  1  reset: asynchronous, active-low.
REQ-005 The block SHALL have port enable  input  1  allows new sample triggers.
REQ-006 The block SHALL have port period_top  input  16  PWM period in clk cycles.
REQ-007 The block SHALL have ports adc_req output 1, adc_ch output 2, adc_ack input 1, adc_data input D_WIDTH  ADC req/ack handshake; ch 0=A, 1=B, 2=C, 3=angle.
REQ-008 The block SHALL have ports currA_out, currB_out, currC_out  output  D_WIDTH  signed phase currents.
REQ-009 The block SHALL have port angle_out  output  D_WIDTH  unsigned resolver angle.
REQ-010 The block SHALL have ports valid output 1 and ready input 1  handshake to the FOC core.
REQ-011 The block SHALL have ports overrun_cnt output 8, busy output 1, cal_done output 1.

Function
REQ-012 Period counter: 0..period_top-1, +1 per cycle, wraps to 0; period_top==0 holds counter at 0 and generates no triggers.
REQ-013 Trigger: counter==0 AND enable AND period_top!=0, one pulse per period.
REQ-014 FSM states IDLE, REQ, PRESENT; busy=1 in any state except IDLE.
REQ-015 IDLE + trigger -> REQ, adc_ch=0; adc_req rises the cycle after the trigger.
REQ-016 REQ: adc_req held high, adc_ch stable, until adc_ack sampled high; adc_data captured on that edge; adc_req low for exactly one cycle before the next channel; adc_ack while adc_req low is ignored.
REQ-017 After channel 3 is captured -> PRESENT; valid rises on the next edge; outputs stay constant while valid=1.
REQ-018 PRESENT: valid AND ready at an edge -> valid=0, IDLE; ready while valid=0 is ignored.
REQ-019 Trigger while not IDLE: trigger dropped, overrun_cnt +1, saturating at 255.
REQ-020 enable deasserted mid-sequence: current sequence completes through PRESENT; no new triggers.
REQ-021 period_top changed mid-period: new value takes effect at the next compare; counter >= period_top wraps to 0.
REQ-022 Minimum latency with adc_ack tied high: trigger to valid = 9 cycles.

Reset
REQ-023 rstb low SHALL asynchronously force: counter 0, IDLE, adc_req 0, adc_ch 0, valid 0, busy 0, all data outputs 0, overrun_cnt 0.
REQ-024 Reset mid-sequence SHALL abort the sequence; no valid is issued for the aborted sequence.
REQ-025 After reset, cal_done SHALL be 0 when CURR_OFFSET_CAL_EN is defined, else 1.

Configuration
REQ-026 Macro CURR_OFFSET_CAL_EN defined: the first 2^CAL_SHIFT sequences after reset SHALL be accumulated per phase (A/B/C) in signed D_WIDTH+CAL_SHIFT registers, with valid suppressed (PRESENT skipped, -> IDLE).
REQ-027 Macro CURR_OFFSET_CAL_EN defined: offset = sum >>> CAL_SHIFT; cal_done=1 thereafter; each curr*_out = raw - offset, saturated to signed D_WIDTH range (0x7FFF / 0x8000); angle_out is never offset.
REQ-028 Macro CURR_OFFSET_CAL_EN undefined: no accumulators; raw data passed through; cal_done tied 1.

Verification
REQ-029 Verification: period_top=100, ack tied 1, ready tied 1, data A=0x0100 B=0xFF00 C=0x0000 angle=0x4000 -> valid 9 cycles after each counter==0, outputs match, every 100 cycles.
REQ-030 Verification: ready held 0 for 250 cycles, period_top=100 -> valid stays high, data stable, overrun_cnt=2 at release; then valid drops one cycle after ready.
REQ-031 Verification: ack delayed 5 cycles per channel -> adc_req held throughout; one low cycle between channels; adc_ch sequence 0,1,2,3.
REQ-032 Verification: rstb pulsed while adc_ch=2 -> all outputs 0 immediately; no valid until the next trigger.
REQ-033 Verification: CURR_OFFSET_CAL_EN, A constant 0x0040 for 16 sequences then 0x0050 -> no valid during cal; cal_done=1; first currA_out=0x0010; A=0x8000 with offset 0x0040 -> saturates to 0x8000.
REQ-034 Verification: period_top=0, or enable=0 -> adc_req never asserts, overrun_cnt stays 0.

Source files
------------

// File: rtl/foc_sample_seq.sv
// foc_sample_seq: samples three phase currents and the resolver angle once per PWM period.
// The ADC is walked through channels 0..3 over a req/ack handshake, and the captured set is
// handed to the FOC core over a valid/ready handshake. A trigger that arrives while a
// sequence is still in flight is dropped and counted in overrun_cnt.
// Optional feature macro: CURR_OFFSET_CAL_EN. When it is defined, the first 2^CAL_SHIFT
// sequences after reset are averaged to find a per-phase current offset, and that offset is
// subtracted (with saturation) from every later current sample.
module foc_sample_seq #(
  parameter int D_WIDTH   = 16,
  parameter int CAL_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               enable,
  input  logic [15:0]        period_top,
  output logic               adc_req,
  output logic [1:0]         adc_ch,
  input  logic               adc_ack,
  input  logic [D_WIDTH-1:0] adc_data,
  output logic [D_WIDTH-1:0] currA_out,
  output logic [D_WIDTH-1:0] currB_out,
  output logic [D_WIDTH-1:0] currC_out,
  output logic [D_WIDTH-1:0] angle_out,
  output logic               valid,
  input  logic               ready,
  output logic [7:0]         overrun_cnt,
  output logic               busy,
  output logic               cal_done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;

  logic [1:0]         state;
  logic [15:0]        cnt;
  logic               trigger;
  logic               capture;
  logic               seq_done;
  logic               cal_run;
  logic [D_WIDTH-1:0] raw_a, raw_b, raw_c, raw_ang;

  // A trigger fires on the first cycle of every period; period_top==0 parks the block.
  assign trigger  = (cnt == 16'd0) && enable && (period_top != 16'd0);
  assign capture  = (state == S_REQ) && adc_req && adc_ack;
  assign seq_done = capture && (adc_ch == 2'd3);
  assign busy     = (state != S_IDLE);

  // Period counter. The >= compare also recovers from period_top shrinking below cnt.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)
      cnt <= 16'd0;
    else if ((period_top == 16'd0) || (cnt >= period_top - 16'd1))
      cnt <= 16'd0;
    else
      cnt <= cnt + 16'd1;
  end

  // Sequencer: IDLE -> REQ (four channels, one low cycle between them) -> PRESENT -> IDLE.
  // PRESENT spends one cycle loading the output registers before raising valid.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= S_IDLE;
      adc_req <= 1'b0;
      adc_ch  <= 2'd0;
      valid   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (trigger) begin
            state   <= S_REQ;
            adc_req <= 1'b1;
            adc_ch  <= 2'd0;
          end
        end
        S_REQ: begin
          if (adc_req) begin
            if (adc_ack) begin
              adc_req <= 1'b0;
              if (adc_ch == 2'd3)
                state <= cal_run ? S_IDLE : S_PRESENT;
              else
                adc_ch <= adc_ch + 2'd1;
            end
          end else begin
            adc_req <= 1'b1;
          end
        end
        S_PRESENT: begin
          if (!valid) begin
            valid <= 1'b1;
          end else if (ready) begin
            valid <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state   <= S_IDLE;
          adc_req <= 1'b0;
          valid   <= 1'b0;
        end
      endcase
    end
  end

  // Raw capture of the ADC word on the acknowledging edge, indexed by channel.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      raw_a   <= '0;
      raw_b   <= '0;
      raw_c   <= '0;
      raw_ang <= '0;
    end else if (capture) begin
      case (adc_ch)
        2'd0:    raw_a   <= adc_data;
        2'd1:    raw_b   <= adc_data;
        2'd2:    raw_c   <= adc_data;
        default: raw_ang <= adc_data;
      endcase
    end
  end

  // Dropped triggers, saturating at 255.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)
      overrun_cnt <= 8'd0;
    else if (trigger && (state != S_IDLE) && (overrun_cnt != 8'hFF))
      overrun_cnt <= overrun_cnt + 8'd1;
  end

`ifdef CURR_OFFSET_CAL_EN
  localparam int ACC_W = D_WIDTH + CAL_SHIFT;

  logic [ACC_W-1:0]     acc_a, acc_b, acc_c;
  logic [CAL_SHIFT-1:0] cal_cnt;
  logic                 cal_done_r;

  assign cal_run  = !cal_done_r;
  assign cal_done = cal_done_r;

  // raw - (acc >>> CAL_SHIFT), clamped to the signed D_WIDTH range.
  function automatic logic [D_WIDTH-1:0] sat_sub(input logic [D_WIDTH-1:0] raw,
                                                 input logic [ACC_W-1:0]   acc);
    logic [ACC_W-1:0] off;
    logic [D_WIDTH:0] diff;
    off  = $signed(acc) >>> CAL_SHIFT;
    diff = {raw[D_WIDTH-1], raw} - off[D_WIDTH:0];
    if (diff[D_WIDTH] != diff[D_WIDTH-1])
      sat_sub = diff[D_WIDTH] ? {1'b1, {(D_WIDTH-1){1'b0}}} : {1'b0, {(D_WIDTH-1){1'b1}}};
    else
      sat_sub = diff[D_WIDTH-1:0];
  endfunction

  // Accumulate each phase once per calibration sequence; done after 2^CAL_SHIFT of them.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      acc_a      <= '0;
      acc_b      <= '0;
      acc_c      <= '0;
      cal_cnt    <= '0;
      cal_done_r <= 1'b0;
    end else if (seq_done && !cal_done_r) begin
      acc_a   <= acc_a + {{CAL_SHIFT{raw_a[D_WIDTH-1]}}, raw_a};
      acc_b   <= acc_b + {{CAL_SHIFT{raw_b[D_WIDTH-1]}}, raw_b};
      acc_c   <= acc_c + {{CAL_SHIFT{raw_c[D_WIDTH-1]}}, raw_c};
      cal_cnt <= cal_cnt + 1'b1;
      if (&cal_cnt)
        cal_done_r <= 1'b1;
    end
  end

  // Output registers load once per presented sequence and hold while valid is high.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      currA_out <= '0;
      currB_out <= '0;
      currC_out <= '0;
      angle_out <= '0;
    end else if ((state == S_PRESENT) && !valid) begin
      currA_out <= sat_sub(raw_a, acc_a);
      currB_out <= sat_sub(raw_b, acc_b);
      currC_out <= sat_sub(raw_c, acc_c);
      angle_out <= raw_ang;
    end
  end
`else
  assign cal_run  = 1'b0;
  // Constant 1; expressed through CAL_SHIFT so the parameter stays referenced here.
  assign cal_done = (CAL_SHIFT >= 0);

  // Output registers load once per presented sequence and hold while valid is high.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      currA_out <= '0;
      currB_out <= '0;
      currC_out <= '0;
      angle_out <= '0;
    end else if ((state == S_PRESENT) && !valid) begin
      currA_out <= raw_a;
      currB_out <= raw_b;
      currC_out <= raw_c;
      angle_out <= raw_ang;
    end
  end
`endif

endmodule

// File: tb/tb_foc_sample_seq.sv
// Directed bench for foc_sample_seq: a small ADC responder model plus a linear sequence of
// steps with hand-computed expectations. The calibration build runs its own sequence.
module tb_foc_sample_seq;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstb = 1'b1;
  logic          enable = 1'b0;
  logic [15:0]   period_top = 16'd0;
  logic          adc_req;
  logic [1:0]    adc_ch;
  logic          adc_ack = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic [DW-1:0] currA_out, currB_out, currC_out, angle_out;
  logic          valid;
  logic          ready = 1'b0;
  logic [7:0]    overrun_cnt;
  logic          busy;
  logic          cal_done;

  int total = 0;
  int bad = 0;
  logic [15:0] tbl [4];
  int ack_delay = 0;

  foc_sample_seq #(.D_WIDTH(DW), .CAL_SHIFT(4)) dut (
    .clk(clk), .rstb(rstb), .enable(enable), .period_top(period_top),
    .adc_req(adc_req), .adc_ch(adc_ch), .adc_ack(adc_ack), .adc_data(adc_data),
    .currA_out(currA_out), .currB_out(currB_out), .currC_out(currC_out),
    .angle_out(angle_out), .valid(valid), .ready(ready),
    .overrun_cnt(overrun_cnt), .busy(busy), .cal_done(cal_done)
  );

  always #5 clk = ~clk;

  // ADC model: ack_delay==0 ties ack high; otherwise ack rises after req has been
  // high for ack_delay cycles. Data always follows the requested channel.
  initial begin
    int rc;
    rc = 0;
    forever begin
      @(negedge clk);
      if (adc_req === 1'b1) rc++;
      else rc = 0;
      adc_ack  = (ack_delay == 0) ? 1'b1 : (rc > ack_delay);
      adc_data = tbl[adc_ch];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rstb = 1'b0;
    @(negedge clk) rstb = 1'b1;
  endtask

  // Counts falling edges until valid is seen, up to lim.
  task automatic wait_valid(input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (valid !== 1'b1 && n < lim);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, viol, seen, ri, g;
    logic prev;
    logic [DW-1:0] held;
    int run [4];
    int gap [3];
    logic [1:0] chs [4];

    tbl[0] = 16'h0100; tbl[1] = 16'hFF00; tbl[2] = 16'h0000; tbl[3] = 16'h4000;

    // Reset state
    #2 rstb = 1'b0;
    @(negedge clk);
    chk("rst_req", adc_req, 0);
    chk("rst_ch", adc_ch, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_currA", currA_out, 0);
    chk("rst_angle", angle_out, 0);
    chk("rst_overrun", overrun_cnt, 0);
`ifdef CURR_OFFSET_CAL_EN
    chk("rst_cal_done", cal_done, 0);
`else
    chk("rst_cal_done", cal_done, 1);
`endif
    rstb = 1'b1;

`ifdef CURR_OFFSET_CAL_EN
    // Calibration: 16 sequences of A=0x0040, then A=0x0050 -> 0x0010, then 0x8000 saturates
    tbl[0] = 16'h0040; tbl[1] = 16'h0000; tbl[2] = 16'h0000; tbl[3] = 16'h1234;
    period_top = 16'd20; ready = 1'b1; enable = 1'b1; ack_delay = 0;
    do_reset();
    seen = 0;
    for (int i = 0; i < 320; i++) begin
      @(negedge clk);
      if (valid === 1'b1) seen++;
    end
    chk("cal_no_valid", seen, 0);
    chk("cal_done_set", cal_done, 1);
    tbl[0] = 16'h0050;
    wait_valid(30, n);
    chk("cal_lat", n, 9);
    chk("cal_currA", currA_out, 16'h0010);
    chk("cal_currB", currB_out, 16'h0000);
    chk("cal_angle", angle_out, 16'h1234);
    tbl[0] = 16'h8000;
    @(negedge clk);
    chk("cal_valid_drop", valid, 0);
    wait_valid(40, n);
    chk("cal_valid2", valid, 1);
    chk("cal_sat", currA_out, 16'h8000);
`else
    // Basic periodic sampling, ack and ready tied high
    period_top = 16'd100; enable = 1'b1; ready = 1'b1; ack_delay = 0;
    do_reset();
    wait_valid(20, n);
    chk("lat1", n, 9);
    chk("currA", currA_out, 16'h0100);
    chk("currB", currB_out, 16'hFF00);
    chk("currC", currC_out, 16'h0000);
    chk("angle", angle_out, 16'h4000);
    chk("busy_present", busy, 1);
    @(negedge clk);
    chk("valid_drop", valid, 0);
    chk("busy_idle", busy, 0);
    wait_valid(120, m);
    chk("lat2", 10 + m, 109);
    chk("overrun_none", overrun_cnt, 0);

    // ready held low: valid and data hold, two triggers dropped
    ready = 1'b0;
    do_reset();
    wait_valid(20, n);
    chk("hold_lat", n, 9);
    held = currA_out;
    viol = 0;
    for (int i = 10; i <= 250; i++) begin
      @(negedge clk);
      if (valid !== 1'b1 || currA_out !== held) viol++;
    end
    chk("hold_stable", viol, 0);
    chk("overrun_2", overrun_cnt, 2);
    ready = 1'b1;
    @(negedge clk);
    chk("release_drop", valid, 0);

    // enable dropped mid-sequence: this sequence completes, no new ones start
    do_reset();
    @(negedge clk);
    enable = 1'b0;
    wait_valid(20, m);
    chk("en_drop_lat", 1 + m, 9);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (adc_req !== 1'b0) seen++;
    end
    chk("en_drop_noreq", seen, 0);
    enable = 1'b1;

    // Delayed ack: 6-cycle req runs, single low cycle between, channels 0..3
    ack_delay = 5;
    do_reset();
    for (int i = 0; i < 4; i++) begin run[i] = 0; chs[i] = 2'd0; end
    for (int i = 0; i < 3; i++) gap[i] = 0;
    ri = -1; g = 0; prev = 1'b0; viol = 0; n = 0;
    while (valid !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
      if (adc_req === 1'b1) begin
        if (!prev) begin
          ri++;
          if (ri > 0 && ri < 4) gap[ri-1] = g;
          if (ri < 4) chs[ri] = adc_ch;
        end else if (ri < 4 && adc_ch !== chs[ri]) viol++;
        if (ri >= 0 && ri < 4) run[ri]++;
        g = 0;
      end else if (ri >= 0) g++;
      prev = (adc_req === 1'b1);
    end
    chk("dly_valid", valid, 1);
    chk("dly_ch_stable", viol, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dly_ch%0d", i), chs[i], i);
      chk($sformatf("dly_run%0d", i), run[i], 6);
    end
    for (int i = 0; i < 3; i++) chk($sformatf("dly_gap%0d", i), gap[i], 1);
    chk("dly_currA", currA_out, 16'h0100);

    // Reset pulsed while channel 2 is requested
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(adc_req === 1'b1 && adc_ch === 2'd2) && n < 150);
    chk("ch2_reached", adc_ch, 2);
    chk("pre_rst_currA", currA_out, 16'h0100);
    rstb = 1'b0;
    #1;
    chk("mid_rst_req", adc_req, 0);
    chk("mid_rst_ch", adc_ch, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_currA", currA_out, 0);
    chk("mid_rst_angle", angle_out, 0);
    ack_delay = 0;
    @(negedge clk) rstb = 1'b1;
    wait_valid(20, n);
    chk("post_rst_lat", n, 9);

    // No triggers with period_top==0 or enable==0
    period_top = 16'd0; enable = 1'b1;
    do_reset();
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (adc_req !== 1'b0) seen++;
    end
    chk("ptop0_noreq", seen, 0);
    chk("ptop0_overrun", overrun_cnt, 0);
    period_top = 16'd100; enable = 1'b0;
    do_reset();
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (adc_req !== 1'b0) seen++;
    end
    chk("en0_noreq", seen, 0);
    chk("en0_overrun", overrun_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
